// File: rtl/rec_tran_param.sv
// Serial frame receiver: synchronises the line, hunts a start pattern, deserialises a
// fixed-length frame into a FWFT byte FIFO and optionally returns a 3-symbol ARQ ack.
module rec_tran_param #(
  parameter int unsigned                PAT_BYTES      = 6,
  parameter logic [PAT_BYTES*8-1:0]     START_PATTERN  = 48'hF6F6F6282828,
  parameter int unsigned                FRAME_BYTES    = 4158,
  parameter int unsigned                FIFO_DEPTH     = 16,
  parameter int unsigned                SYNC_STAGES    = 2,
  parameter int unsigned                ACK_SYM_CYCLES = 1,
  parameter int unsigned                CRC_TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_otn_tx_data,
  output logic        o_otn_rx_ack,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_last,
  output logic        o_frame_data_valid,
  input  logic        i_frame_data_ready,
  input  logic        i_arq_en,
  input  logic        i_arq_en_valid,
  input  logic        i_crc_err,
  input  logic        i_crc_err_valid,
  output logic        o_locked,
  output logic        o_overflow,
  output logic [15:0] o_frames_good,
  output logic [15:0] o_frames_bad
);

  localparam int unsigned WinW = PAT_BYTES * 8;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned AckW = $clog2(ACK_SYM_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {StHunt, StGetFrame, StWaitCrc, StSendAck} state_t;

  state_t            r_state, w_state_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WinW-1:0]   r_win;
  logic [WinW-1:0]   w_win_nxt;
  logic              w_bit;
  logic              w_match;
  logic [2:0]        r_bit_cnt, w_bit_cnt_d;
  logic [15:0]       r_byte_cnt, w_byte_cnt_d;
  logic [ToW-1:0]    r_to, w_to_d;
  logic [1:0]        r_sym, w_sym_d;
  logic [AckW-1:0]   r_hold, w_hold_d;
  logic              r_good, w_good_d;
  logic              r_ack, w_ack_d;
  logic              r_arq;
  logic              r_overflow;
  logic [15:0]       r_good_cnt, r_bad_cnt;
  logic              w_inc_good, w_inc_bad;
  logic              w_last_byte;
  logic              w_wr;
  logic [8:0]        w_wdata;

  logic [8:0]        r_mem [FIFO_DEPTH];
  logic [PtrW:0]     r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]     w_count;
  logic              w_full, w_empty, w_pop, w_push;

  assign w_bit       = r_sync[SYNC_STAGES-1];
  assign w_win_nxt   = {r_win[WinW-2:0], w_bit};
  // Compare against the value being loaded so the next bit is payload bit 7.
  assign w_match     = (w_win_nxt == START_PATTERN);
  assign w_last_byte = (r_byte_cnt == 16'(FRAME_BYTES - 1));
  assign w_wdata     = {w_last_byte, r_win[6:0], w_bit};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_win  <= '1;
      r_arq  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_otn_tx_data};
      r_win  <= w_win_nxt;
      if (i_arq_en_valid) r_arq <= i_arq_en;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bit_cnt_d  = r_bit_cnt;
    w_byte_cnt_d = r_byte_cnt;
    w_to_d       = r_to;
    w_sym_d      = r_sym;
    w_hold_d     = r_hold;
    w_good_d     = r_good;
    w_ack_d      = 1'b1;
    w_wr         = 1'b0;
    w_inc_good   = 1'b0;
    w_inc_bad    = 1'b0;
    case (r_state)
      StHunt: begin
        if (w_match) begin
          w_state_d    = StGetFrame;
          w_bit_cnt_d  = '0;
          w_byte_cnt_d = '0;
        end
      end
      StGetFrame: begin
        w_bit_cnt_d = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          w_wr         = 1'b1;
          w_byte_cnt_d = r_byte_cnt + 16'd1;
          if (w_last_byte) begin
            if (r_arq) begin
              w_state_d = StWaitCrc;
              w_to_d    = '0;
            end else begin
              w_state_d  = StHunt;
              w_inc_good = 1'b1;
            end
          end
        end
      end
      StWaitCrc: begin
        w_to_d = r_to + ToW'(1);
        if (i_crc_err_valid || (r_to == ToW'(CRC_TIMEOUT - 1))) begin
          w_state_d = StSendAck;
          w_good_d  = i_crc_err_valid && !i_crc_err;
          w_sym_d   = 2'd0;
          w_hold_d  = '0;
        end
      end
      StSendAck: begin
        w_ack_d = (r_sym == 2'd1) ? r_good : 1'b0;
        if (r_hold == AckW'(ACK_SYM_CYCLES - 1)) begin
          w_hold_d = '0;
          if (r_sym == 2'd2) begin
            w_state_d  = StHunt;
            w_inc_good = r_good;
            w_inc_bad  = !r_good;
          end else begin
            w_sym_d = r_sym + 2'd1;
          end
        end else begin
          w_hold_d = r_hold + AckW'(1);
        end
      end
      default: w_state_d = StHunt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StHunt;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_to       <= '0;
      r_sym      <= '0;
      r_hold     <= '0;
      r_good     <= 1'b0;
      r_ack      <= 1'b1;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_to       <= w_to_d;
      r_sym      <= w_sym_d;
      r_hold     <= w_hold_d;
      r_good     <= w_good_d;
      r_ack      <= w_ack_d;
      if (w_inc_good && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (w_inc_bad && (r_bad_cnt != 16'hFFFF))   r_bad_cnt  <= r_bad_cnt + 16'd1;
    end
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == (PtrW + 1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && i_frame_data_ready;
  assign w_push  = w_wr && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PtrW-1:0]] <= w_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PtrW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PtrW + 1)'(1);
      r_overflow <= w_wr && !w_push;
    end
  end

  assign o_frame_data_valid = !w_empty;
  assign o_frame_data       = w_empty ? 8'h00 : r_mem[r_rd_ptr[PtrW-1:0]][7:0];
  assign o_frame_last       = w_empty ? 1'b0 : r_mem[r_rd_ptr[PtrW-1:0]][8];
  assign o_otn_rx_ack       = r_ack;
  assign o_locked           = (r_state == StGetFrame);
  assign o_overflow         = r_overflow;
  assign o_frames_good      = r_good_cnt;
  assign o_frames_bad       = r_bad_cnt;

endmodule
